// File: rtl/counter7_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : counter7_pkg                                               |
// | Purpose  : Shared constants and count type for the mod-7 arbitrated   |
// |            counter (counter7_arb, mod7_step).                         |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package counter7_pkg;

  // 3-bit count; only 0..6 are legal values on the output
  typedef logic [2:0] count_t;

  localparam count_t MOD7_MAX = 3'd6;  // highest legal count
  localparam count_t Y_THRESH = 3'd3;  // y is high at or above this count
  localparam logic   DIR_UP   = 1'b0;  // dir bit value for an up step
  localparam logic   DIR_DOWN = 1'b1;  // dir bit value for a down step

endpackage : counter7_pkg
`default_nettype wire

// File: rtl/mod7_step.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : mod7_step                                                  |
// | Purpose  : Combinational next-count for one up/down step, mod 7.      |
// |            boundary flags a step that crosses (wrap build) or hits    |
// |            (saturate build) the 6/0 limit.                            |
// | Config   : COUNTER7_ARB_SAT_EN defined -> saturate at 0 and 6,        |
// |            undefined -> wrap 6->0 / 0->6.                             |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module mod7_step
  import counter7_pkg::*;
(
  input  count_t q,
  input  logic   dir,
  output count_t next_q,
  output logic   boundary
);

`ifdef COUNTER7_ARB_SAT_EN
  localparam bit c_SAT_EN = 1'b1;
`else
  localparam bit c_SAT_EN = 1'b0;
`endif

  // an illegal 7 is treated as 0 so a corrupted count can never propagate
  count_t w_q;

  // step the (normalised) count one position in the requested direction
  always_comb begin
    w_q      = (q > MOD7_MAX) ? '0 : q;
    next_q   = w_q;
    boundary = 1'b0;
    if (dir == DIR_UP) begin
      if (w_q == MOD7_MAX) begin
        boundary = 1'b1;
        next_q   = c_SAT_EN ? MOD7_MAX : '0;
      end else begin
        next_q = w_q + 3'd1;
      end
    end else begin
      if (w_q == '0) begin
        boundary = 1'b1;
        next_q   = c_SAT_EN ? '0 : MOD7_MAX;
      end else begin
        next_q = w_q - 3'd1;
      end
    end
  end

endmodule : mod7_step
`default_nettype wire

// File: rtl/counter7_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : counter7_arb                                               |
// | Purpose  : Two requesters share one mod-7 up/down counter. Requests   |
// |            are arbitrated round-robin; the winner's step is applied   |
// |            at the same edge that registers its one-cycle grant, so    |
// |            gnt, q and wrap all change together one cycle after the    |
// |            request is presented.                                      |
// | Config   : COUNTER7_ARB_SAT_EN (see mod7_step) selects saturating     |
// |            instead of wrapping steps.                                 |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module counter7_arb
  import counter7_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic [1:0] dir,
  output logic [1:0] gnt,
  output logic [2:0] q,
  output logic       y,
  output logic       wrap
);

  count_t     r_q;
  logic [1:0] r_gnt;
  logic       r_wrap;
  logic       r_ptr;       // requester that wins the next contention

  logic       w_win_vld;
  logic       w_win;
  logic       w_dir;
  count_t     w_next_q;
  count_t     w_q_hold;
  logic       w_boundary;

  // pick at most one requester; ties go to the round-robin pointer
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = 1'b0;
    case (req)
      2'b01: begin w_win_vld = 1'b1; w_win = 1'b0;  end
      2'b10: begin w_win_vld = 1'b1; w_win = 1'b1;  end
      2'b11: begin w_win_vld = 1'b1; w_win = r_ptr; end
      default: begin w_win_vld = 1'b0; w_win = 1'b0; end
    endcase
  end

  assign w_dir    = dir[w_win];
  // idle cycles hold the count, but still scrub an illegal 7 back to 0
  assign w_q_hold = (r_q > MOD7_MAX) ? '0 : r_q;

  mod7_step u_step (
    .q        (r_q),
    .dir      (w_dir),
    .next_q   (w_next_q),
    .boundary (w_boundary)
  );

  // count, grant and pointer registers; clear drops the request but keeps the pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_gnt  <= 2'b00;
      r_wrap <= 1'b0;
      r_ptr  <= 1'b0;
    end else if (clr) begin
      r_q    <= '0;
      r_gnt  <= 2'b00;
      r_wrap <= 1'b0;
    end else if (w_win_vld) begin
      r_q    <= w_next_q;
      r_gnt  <= w_win ? 2'b10 : 2'b01;
      r_wrap <= w_boundary;
      r_ptr  <= ~w_win;
    end else begin
      r_q    <= w_q_hold;
      r_gnt  <= 2'b00;
      r_wrap <= 1'b0;
    end
  end

  assign q    = r_q;
  assign gnt  = r_gnt;
  assign wrap = r_wrap;
  assign y    = (r_q >= Y_THRESH);

endmodule : counter7_arb
`default_nettype wire

// File: tb/tb_counter7_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_counter7_arb                                            |
// | Purpose  : Self-checking bench for counter7_arb: directed scenarios   |
// |            with literal expectations, then randomized traffic checked |
// |            every cycle against a behavioural model.                   |
// | Config   : honours COUNTER7_ARB_SAT_EN like the design.               |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_counter7_arb;

`ifdef COUNTER7_ARB_SAT_EN
  localparam bit c_SAT = 1'b1;
`else
  localparam bit c_SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, clr;
  logic [1:0] req, dir;
  logic [1:0] gnt;
  logic [2:0] q;
  logic       y, wrap;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  counter7_arb dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .req  (req),
    .dir  (dir),
    .gnt  (gnt),
    .q    (q),
    .y    (y),
    .wrap (wrap)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_q   = 0;
  int         m_fav = 0;     // requester that wins a tie
  logic [1:0] m_gnt = 2'b00;
  bit         m_wrap = 1'b0;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    int nq, w, nfav;
    logic [1:0] ng;
    bit nw;
    nq = m_q; ng = 2'b00; nw = 1'b0; w = -1; nfav = m_fav;
    if (rst) begin
      nq = 0; nfav = 0;
    end else if (clr) begin
      nq = 0;
    end else begin
      if (req == 2'b01)      w = 0;
      else if (req == 2'b10) w = 1;
      else if (req == 2'b11) w = m_fav;
      if (w >= 0) begin
        ng   = (w == 0) ? 2'b01 : 2'b10;
        nfav = 1 - w;
        if (dir[w] == 1'b0) begin
          nw = (m_q == 6);
          nq = (c_SAT && m_q == 6) ? 6 : (m_q + 1) % 7;
        end else begin
          nw = (m_q == 0);
          nq = (c_SAT && m_q == 0) ? 0 : (m_q + 6) % 7;
        end
      end
    end
    m_q     <= nq;
    m_gnt   <= ng;
    m_wrap  <= nw;
    m_fav   <= nfav;
    m_valid <= 1'b1;
  end

  // compare every cycle, mid-way between active edges
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_q",    {5'd0, q},    8'(m_q));
      chk("model_gnt",  {6'd0, gnt},  {6'd0, m_gnt});
      chk("model_wrap", {7'd0, wrap}, {7'd0, m_wrap});
      chk("model_y",    {7'd0, y},    {7'd0, (m_q >= 3)});
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step(input logic r, input logic c, input logic [1:0] rq, input logic [1:0] d);
    rst = r; clr = c; req = rq; dir = d;
    @(negedge clk);
  endtask

  logic [2:0] sweep_q [8];
  logic       sweep_w [8];

  initial begin
    if (c_SAT) begin
      sweep_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd6};
      sweep_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    end else begin
      sweep_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
      sweep_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    end

    // reset held two cycles with both requests pending
    rst = 1'b1; clr = 1'b0; req = 2'b11; dir = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_q",   {5'd0, q},   8'd0);
      chk("rst_gnt", {6'd0, gnt}, 8'd0);
      chk("rst_y",   {7'd0, y},   8'd0);
      if (i == 0) step(1'b1, 1'b0, 2'b11, 2'b00);
    end

    // first contention after reset goes to requester 0, then up sweep
    step(1'b0, 1'b0, 2'b11, 2'b00);
    chk("first_gnt", {6'd0, gnt}, 8'd1);
    chk("sweep_q0",  {5'd0, q},   {5'd0, sweep_q[0]});
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b0, 2'b01, 2'b00);
      chk("sweep_q",    {5'd0, q},    {5'd0, sweep_q[i]});
      chk("sweep_wrap", {7'd0, wrap}, {7'd0, sweep_w[i]});
      if (i == 1) chk("sweep_y_lo", {7'd0, y}, 8'd0);
      if (i == 2) chk("sweep_y_hi", {7'd0, y}, 8'd1);
    end

    // clear collision at q=5; pointer favours requester 1 across the clear
    step(1'b0, 1'b1, 2'b00, 2'b00);
    repeat (5) step(1'b0, 1'b0, 2'b01, 2'b00);
    chk("pre_clr_q", {5'd0, q}, 8'd5);
    step(1'b0, 1'b1, 2'b01, 2'b00);
    chk("clr_q",   {5'd0, q},   8'd0);
    chk("clr_gnt", {6'd0, gnt}, 8'd0);
    step(1'b0, 1'b0, 2'b11, 2'b00);
    chk("post_clr_gnt", {6'd0, gnt}, 8'd2);
    chk("post_clr_q",   {5'd0, q},   8'd1);

    // contention from q=3: requester 0 up, requester 1 down
    repeat (2) step(1'b0, 1'b0, 2'b10, 2'b00);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 2'b11, 2'b10);
      chk("cont_gnt", {6'd0, gnt}, (i % 2 == 0) ? 8'd1 : 8'd2);
      chk("cont_q",   {5'd0, q},   (i % 2 == 0) ? 8'd4 : 8'd3);
    end

    // down step at zero
    step(1'b0, 1'b1, 2'b00, 2'b00);
    step(1'b0, 1'b0, 2'b10, 2'b10);
    chk("down_gnt",  {6'd0, gnt},  8'd2);
    chk("down_q",    {5'd0, q},    c_SAT ? 8'd0 : 8'd6);
    chk("down_wrap", {7'd0, wrap}, 8'd1);
    chk("down_y",    {7'd0, y},    c_SAT ? 8'd0 : 8'd1);

    // mid-operation reset at q=4 restores pointer to requester 0
    step(1'b0, 1'b1, 2'b00, 2'b00);
    repeat (4) step(1'b0, 1'b0, 2'b01, 2'b00);
    step(1'b1, 1'b0, 2'b11, 2'b00);
    chk("midrst_q",   {5'd0, q},   8'd0);
    chk("midrst_gnt", {6'd0, gnt}, 8'd0);
    step(1'b0, 1'b0, 2'b11, 2'b00);
    chk("midrst_next_gnt", {6'd0, gnt}, 8'd1);

    // randomized traffic, checked by the model process
    repeat (2000) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_counter7_arb
`default_nettype wire

// File: doc/counter7_arb.md
COUNTER7_ARB -- requirements
Module: counter7_arb

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port clr, input, 1, synchronous clear of the count.
REQ-004 SHALL have port req, input, 2, step request per requester; bit i belongs to requester i.
REQ-005 SHALL have port dir, input, 2, step direction per requester; bit i=0 means up, bit i=1 means down.
REQ-006 SHALL have port gnt, output, 2, one-hot grant pulse, registered.
REQ-007 SHALL have port q, output, 3, current count, range 0..6, registered.
REQ-008 SHALL have port y, output, 1, threshold flag: 0 when q<=2, 1 when q>=3.
REQ-009 SHALL have port wrap, output, 1, one-cycle pulse; set when the granted step crossed the 6/0 boundary (or hit it, in saturate mode).

Function
REQ-010 SHALL sample req and dir every cycle and grant at most one requester per cycle.
REQ-011 Grant latency SHALL be 1 cycle: a request sampled at edge N gives gnt high after edge N+1, and q shows the stepped value in that same cycle.
REQ-012 Single request: the requesting bit SHALL be granted.
REQ-013 Both requesting: the requester not granted most recently SHALL win (round-robin); the pointer SHALL update only on a grant.
REQ-014 Up step: q SHALL go 0->1->...->6->0. Down step: q SHALL go 6->5->...->0->6. All arithmetic is mod 7.
REQ-015 The value 7 SHALL never appear on q; internal value 7 SHALL be forced to 0 on the next edge.
REQ-016 gnt SHALL be a single-cycle pulse; a requester holding req high SHALL be granted again under arbitration (no implicit hold-off).
REQ-017 Cycles with no grant SHALL leave q unchanged, gnt=00, wrap=0.
REQ-018 clr=1 SHALL set q=0 on the next edge, suppress any grant that cycle (gnt=00, wrap=0), and leave the round-robin pointer unchanged.
REQ-019 y SHALL be combinational from registered q, with no added latency.

Reset
REQ-020 rst=1 SHALL set q=0, gnt=00, wrap=0, y=0, and set the pointer so that requester 0 wins the first contention.
REQ-021 rst SHALL take priority over clr and over requests; a request pending during reset SHALL be dropped, not queued.
REQ-022 After rst falls, the first grant SHALL occur no earlier than 1 cycle after requests are sampled.

Configuration
REQ-023 Macro COUNTER7_ARB_SAT_EN defined: steps SHALL saturate. Up at 6 stays 6; down at 0 stays 0. wrap pulses on the saturated grant. The grant is still issued.
REQ-024 Macro undefined: steps SHALL wrap per REQ-014, with wrap pulsing on 6->0 (up) and 0->6 (down).

Structure
REQ-025 Shared package counter7_pkg SHALL hold the constants MOD7_MAX=6, Y_THRESH=3, DIR_UP=0 and DIR_DOWN=1, plus the 3-bit count typedef.
REQ-026 The next-count logic SHALL be one combinational sub-module, mod7_step (inputs: q, dir; outputs: next_q, boundary), instantiated once.
REQ-027 The arbiter pointer, grant register and count register SHALL reside in counter7_arb.

Verification
REQ-028 Reset: rst=1 for 2 cycles with req=11 -> q=0, gnt=00, y=0 throughout. First grant after release goes to requester 0.
REQ-029 Up sweep: req=01, dir=00 for 8 cycles -> q=1,2,3,4,5,6,0,1. y rises when q=3. wrap pulses once at 6->0 (saturate build: q stays 6, wrap pulses every cycle from the 7th grant on).
REQ-030 Contention: req=11, dir=10 from q=3 -> gnt alternates 01,10,01,... and q alternates 4,3,4,3.
REQ-031 Down wrap: q=0, req=10, dir=10 -> gnt=10, q=6, wrap=1, y=1 (saturate build: q=0, wrap=1).
REQ-032 Clear collision: q=5 with req=01 and clr=1 in the same cycle -> q=0, gnt=00. The next grant goes to requester 0 if the pointer favoured it before the clear.
REQ-033 Mid-operation reset: rst asserted while req=11 at q=4 -> next cycle q=0, gnt=00; the pointer is restored to favour requester 0.
